// File: rtl/ysyx_lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, error codes,
// FSM states and a small alignment helper.
package ysyx_lsu_pkg;

  // Access size encodings (log2 of the byte count)
  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  // Response error codes
  localparam logic [1:0] ERR_OK       = 2'd0;
  localparam logic [1:0] ERR_MISALIGN = 2'd1;
  localparam logic [1:0] ERR_BUS      = 2'd2;
  localparam logic [1:0] ERR_SIZE     = 2'd3;

  // LSU control states
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BUS_REQ  = 2'd1,
    BUS_WAIT = 2'd2,
    RESP     = 2'd3
  } lsu_state_e;

  // True when the low address bits are not a multiple of the access size
  function automatic logic addr_misaligned(input logic [2:0] low, input logic [1:0] size);
    logic mis;
    case (size)
      SZ_B:    mis = 1'b0;
      SZ_H:    mis = low[0];
      SZ_W:    mis = |low[1:0];
      SZ_D:    mis = |low[2:0];
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/ysyx_lsu_align.sv
// Byte-lane steering for the LSU: store data shift and strobe generation,
// and load lane extraction with sign/zero extension. Purely combinational.
module ysyx_lsu_align
  import ysyx_lsu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NB    = XLEN / 8,
  parameter int OFF_W = $clog2(XLEN / 8)
) (
  input  logic [1:0]       st_size,
  input  logic [OFF_W-1:0] st_off,
  input  logic [XLEN-1:0]  st_wdata,
  output logic [XLEN-1:0]  st_wdata_sh,
  output logic [NB-1:0]    st_wstrb,
  input  logic [1:0]       ld_size,
  input  logic             ld_unsigned,
  input  logic [OFF_W-1:0] ld_off,
  input  logic [XLEN-1:0]  ld_rdata,
  output logic [XLEN-1:0]  ld_data
);

  int                nbytes_s;
  logic [NB-1:0]     strb_base_s;
  int                nbits_s;
  logic [XLEN-1:0]   shifted_s;
  logic [XLEN-1:0]   keep_s;
  logic              sign_s;

  // Store path: move right-justified data into its lanes and mark the touched bytes
  always_comb begin
    st_wdata_sh = st_wdata << {st_off, 3'b000};
    nbytes_s    = 32'd1 << st_size;
    strb_base_s = '0;
    for (int i = 0; i < NB; i++) begin
      strb_base_s[i] = (i < nbytes_s);
    end
    st_wstrb = strb_base_s << st_off;
  end

  // Load path: bring the addressed field down to bit 0, then extend from its top bit
  always_comb begin
    shifted_s = ld_rdata >> {ld_off, 3'b000};
    nbits_s   = 32'd8 << ld_size;
    keep_s    = '0;
    sign_s    = 1'b0;
    for (int i = 0; i < XLEN; i++) begin
      keep_s[i] = (i < nbits_s);
      sign_s    = sign_s | (shifted_s[i] & (i == nbits_s - 1));
    end
    if (ld_unsigned) begin
      ld_data = shifted_s & keep_s;
    end else begin
      ld_data = (shifted_s & keep_s) | ({XLEN{sign_s}} & ~keep_s);
    end
  end

endmodule

// File: rtl/ysyx_lsu.sv
// Multi-cycle load/store unit: accepts one EXU operation at a time, traps
// illegal or misaligned accesses, runs a split request/response bus cycle and
// returns the extended load data or store completion to write-back.
module ysyx_lsu
  import ysyx_lsu_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [XLEN/8-1:0] mem_wstrb,
  input  logic              mem_resp_valid,
  input  logic [XLEN-1:0]   mem_rdata,
  input  logic              mem_resp_err,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [XLEN-1:0]   resp_rdata,
  output logic [1:0]        resp_err
);

  localparam int NB    = XLEN / 8;
  localparam int OFF_W = $clog2(NB);
  localparam logic DWORD_OK = (XLEN == 64);

  lsu_state_e        state_r;
  lsu_state_e        state_nxt_s;
  logic [1:0]        size_r;
  logic              uns_r;
  logic [OFF_W-1:0]  off_r;
  logic              mem_we_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [XLEN-1:0]   mem_wdata_r;
  logic [NB-1:0]     mem_wstrb_r;
  logic [XLEN-1:0]   resp_rdata_r;
  logic [1:0]        resp_err_r;
  logic [1:0]        trap_err_s;
  logic [XLEN-1:0]   st_wdata_sh_s;
  logic [NB-1:0]     st_wstrb_s;
  logic [XLEN-1:0]   ld_data_s;

  ysyx_lsu_align #(.XLEN(XLEN)) u_align (
    .st_size     (req_size),
    .st_off      (req_addr[OFF_W-1:0]),
    .st_wdata    (req_wdata),
    .st_wdata_sh (st_wdata_sh_s),
    .st_wstrb    (st_wstrb_s),
    .ld_size     (size_r),
    .ld_unsigned (uns_r),
    .ld_off      (off_r),
    .ld_rdata    (mem_rdata),
    .ld_data     (ld_data_s)
  );

  // Classify the incoming request: illegal size wins over misalignment
  always_comb begin
    if ((req_size == SZ_D) && !DWORD_OK) begin
      trap_err_s = ERR_SIZE;
    end else if (addr_misaligned(req_addr[2:0], req_size)) begin
      trap_err_s = ERR_MISALIGN;
    end else begin
      trap_err_s = ERR_OK;
    end
  end

  // State register; reset abandons any bus transaction in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; trapped requests skip the bus entirely
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (req_valid) begin
          state_nxt_s = (trap_err_s != ERR_OK) ? RESP : BUS_REQ;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      BUS_REQ: begin
        if (mem_req_ready) begin
          state_nxt_s = BUS_WAIT;
        end else begin
          state_nxt_s = BUS_REQ;
        end
      end
      BUS_WAIT: begin
        if (mem_resp_valid) begin
          state_nxt_s = RESP;
        end else begin
          state_nxt_s = BUS_WAIT;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = RESP;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Handshake outputs decoded from state only, so req_* never reaches mem_* combinationally
  always_comb begin
    req_ready     = 1'b0;
    mem_req_valid = 1'b0;
    resp_valid    = 1'b0;
    case (state_r)
      IDLE:     req_ready     = 1'b1;
      BUS_REQ:  mem_req_valid = 1'b1;
      BUS_WAIT: mem_req_valid = 1'b0;
      RESP:     resp_valid    = 1'b1;
      default:  req_ready     = 1'b0;
    endcase
  end

  // Request latch (pre-aligned bus fields) and result capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      size_r       <= SZ_B;
      uns_r        <= 1'b0;
      off_r        <= '0;
      mem_we_r     <= 1'b0;
      mem_addr_r   <= '0;
      mem_wdata_r  <= '0;
      mem_wstrb_r  <= '0;
      resp_rdata_r <= '0;
      resp_err_r   <= ERR_OK;
    end else begin
      case (state_r)
        IDLE: begin
          if (req_valid) begin
            size_r       <= req_size;
            uns_r        <= req_unsigned;
            off_r        <= req_addr[OFF_W-1:0];
            mem_we_r     <= req_we;
            mem_addr_r   <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            mem_wdata_r  <= req_we ? st_wdata_sh_s : '0;
            mem_wstrb_r  <= req_we ? st_wstrb_s : '0;
            resp_rdata_r <= '0;
            resp_err_r   <= trap_err_s;
          end
        end
        BUS_WAIT: begin
          if (mem_resp_valid) begin
            if (mem_resp_err) begin
              resp_err_r   <= ERR_BUS;
              resp_rdata_r <= '0;
            end else begin
              resp_err_r   <= ERR_OK;
              resp_rdata_r <= mem_we_r ? '0 : ld_data_s;
            end
          end
        end
        default: begin
          resp_err_r <= resp_err_r;
        end
      endcase
    end
  end

  assign mem_we     = mem_we_r;
  assign mem_addr   = mem_addr_r;
  assign mem_wdata  = mem_wdata_r;
  assign mem_wstrb  = mem_wstrb_r;
  assign resp_rdata = resp_rdata_r;
  assign resp_err   = resp_err_r;

endmodule

// File: tb/tb_ysyx_lsu.sv
// Directed bench for ysyx_lsu: a 32-bit and a 64-bit instance share stimulus,
// with sel64 routing handshakes to one of them at a time.
module tb_ysyx_lsu;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        sel64;
  logic        req_valid, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr;
  logic [63:0] req_wdata;
  logic        mem_req_ready, mem_resp_valid, mem_resp_err, resp_ready;
  logic [63:0] mem_rdata;

  logic        a_req_valid, a_mem_req_ready, a_mem_resp_valid, a_resp_ready;
  logic        a_req_ready, a_mem_req_valid, a_mem_we, a_resp_valid;
  logic [31:0] a_mem_addr, a_mem_wdata, a_resp_rdata;
  logic [3:0]  a_mem_wstrb;
  logic [1:0]  a_resp_err;

  logic        b_req_valid, b_mem_req_ready, b_mem_resp_valid, b_resp_ready;
  logic        b_req_ready, b_mem_req_valid, b_mem_we, b_resp_valid;
  logic [31:0] b_mem_addr;
  logic [63:0] b_mem_wdata, b_resp_rdata;
  logic [7:0]  b_mem_wstrb;
  logic [1:0]  b_resp_err;

  assign a_req_valid      = req_valid & ~sel64;
  assign a_mem_req_ready  = mem_req_ready & ~sel64;
  assign a_mem_resp_valid = mem_resp_valid & ~sel64;
  assign a_resp_ready     = resp_ready & ~sel64;
  assign b_req_valid      = req_valid & sel64;
  assign b_mem_req_ready  = mem_req_ready & sel64;
  assign b_mem_resp_valid = mem_resp_valid & sel64;
  assign b_resp_ready     = resp_ready & sel64;

  logic        o_req_ready, o_mem_req_valid, o_mem_we, o_resp_valid;
  logic [31:0] o_mem_addr;
  logic [63:0] o_mem_wdata, o_resp_rdata;
  logic [7:0]  o_mem_wstrb;
  logic [1:0]  o_resp_err;

  assign o_req_ready     = sel64 ? b_req_ready     : a_req_ready;
  assign o_mem_req_valid = sel64 ? b_mem_req_valid : a_mem_req_valid;
  assign o_mem_we        = sel64 ? b_mem_we        : a_mem_we;
  assign o_resp_valid    = sel64 ? b_resp_valid    : a_resp_valid;
  assign o_mem_addr      = sel64 ? b_mem_addr      : a_mem_addr;
  assign o_mem_wdata     = sel64 ? b_mem_wdata     : {32'h0, a_mem_wdata};
  assign o_mem_wstrb     = sel64 ? b_mem_wstrb     : {4'h0, a_mem_wstrb};
  assign o_resp_rdata    = sel64 ? b_resp_rdata    : {32'h0, a_resp_rdata};
  assign o_resp_err      = sel64 ? b_resp_err      : a_resp_err;

  ysyx_lsu #(.XLEN(32), .ADDR_W(32)) dut32 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata[31:0]),
    .mem_req_valid(a_mem_req_valid), .mem_req_ready(a_mem_req_ready),
    .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
    .mem_wstrb(a_mem_wstrb), .mem_resp_valid(a_mem_resp_valid),
    .mem_rdata(mem_rdata[31:0]), .mem_resp_err(mem_resp_err),
    .resp_valid(a_resp_valid), .resp_ready(a_resp_ready),
    .resp_rdata(a_resp_rdata), .resp_err(a_resp_err)
  );

  ysyx_lsu #(.XLEN(64), .ADDR_W(32)) dut64 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .mem_req_valid(b_mem_req_valid), .mem_req_ready(b_mem_req_ready),
    .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_wstrb(b_mem_wstrb), .mem_resp_valid(b_mem_resp_valid),
    .mem_rdata(mem_rdata), .mem_resp_err(mem_resp_err),
    .resp_valid(b_resp_valid), .resp_ready(b_resp_ready),
    .resp_rdata(b_resp_rdata), .resp_err(b_resp_err)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Both instances must show the idle/reset output values
  task automatic chk_zero(input string tag);
    chk({tag, " a_req_ready"},   {63'h0, a_req_ready},     64'h1);
    chk({tag, " a_mem_valid"},   {63'h0, a_mem_req_valid}, 64'h0);
    chk({tag, " a_resp_valid"},  {63'h0, a_resp_valid},    64'h0);
    chk({tag, " a_mem_we"},      {63'h0, a_mem_we},        64'h0);
    chk({tag, " a_mem_addr"},    {32'h0, a_mem_addr},      64'h0);
    chk({tag, " a_mem_wdata"},   {32'h0, a_mem_wdata},     64'h0);
    chk({tag, " a_mem_wstrb"},   {60'h0, a_mem_wstrb},     64'h0);
    chk({tag, " a_resp_rdata"},  {32'h0, a_resp_rdata},    64'h0);
    chk({tag, " a_resp_err"},    {62'h0, a_resp_err},      64'h0);
    chk({tag, " b_req_ready"},   {63'h0, b_req_ready},     64'h1);
    chk({tag, " b_mem_valid"},   {63'h0, b_mem_req_valid}, 64'h0);
    chk({tag, " b_resp_valid"},  {63'h0, b_resp_valid},    64'h0);
    chk({tag, " b_mem_addr"},    {32'h0, b_mem_addr},      64'h0);
    chk({tag, " b_mem_wdata"},   b_mem_wdata,              64'h0);
    chk({tag, " b_mem_wstrb"},   {56'h0, b_mem_wstrb},     64'h0);
    chk({tag, " b_resp_rdata"},  b_resp_rdata,             64'h0);
  endtask

  typedef struct {
    logic        sel64;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic [63:0] rdata;
    logic        berr;
    logic        trap;
    logic [31:0] e_addr;
    logic [63:0] e_wdata;
    logic [7:0]  e_wstrb;
    logic [63:0] e_rdata;
    logic [1:0]  e_err;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs[NV];

  // Minimum-latency run of one vector with cycle-exact expectations
  task automatic run_vec(input int idx, input vec_t v);
    string t;
    t = $sformatf("v%0d", idx);
    sel64 = v.sel64;
    #1;
    chk({t, " req_ready"}, {63'h0, o_req_ready}, 64'h1);
    req_valid = 1'b1; req_we = v.we; req_size = v.size; req_unsigned = v.uns;
    req_addr = v.addr; req_wdata = v.wdata;
    step();
    req_valid = 1'b0;
    if (v.trap) begin
      chk({t, " trap resp_valid"}, {63'h0, o_resp_valid},    64'h1);
      chk({t, " trap mem_valid"},  {63'h0, o_mem_req_valid}, 64'h0);
      chk({t, " trap err"},        {62'h0, o_resp_err},      {62'h0, v.e_err});
      chk({t, " trap rdata"},      o_resp_rdata,             64'h0);
    end else begin
      chk({t, " mem_valid"},  {63'h0, o_mem_req_valid}, 64'h1);
      chk({t, " resp_valid0"}, {63'h0, o_resp_valid},   64'h0);
      chk({t, " mem_addr"},   {32'h0, o_mem_addr},      {32'h0, v.e_addr});
      chk({t, " mem_we"},     {63'h0, o_mem_we},        {63'h0, v.we});
      chk({t, " mem_wdata"},  o_mem_wdata,              v.e_wdata);
      chk({t, " mem_wstrb"},  {56'h0, o_mem_wstrb},     {56'h0, v.e_wstrb});
      mem_req_ready = 1'b1;
      step();
      mem_req_ready = 1'b0;
      chk({t, " mem_valid_drop"}, {63'h0, o_mem_req_valid}, 64'h0);
      mem_resp_valid = 1'b1; mem_rdata = v.rdata; mem_resp_err = v.berr;
      step();
      mem_resp_valid = 1'b0; mem_resp_err = 1'b0;
      chk({t, " resp_valid"}, {63'h0, o_resp_valid}, 64'h1);
      chk({t, " resp_rdata"}, o_resp_rdata,          v.e_rdata);
      chk({t, " resp_err"},   {62'h0, o_resp_err},   {62'h0, v.e_err});
    end
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    chk({t, " resp_done"},  {63'h0, o_resp_valid},    64'h0);
    chk({t, " ready_back"}, {63'h0, o_req_ready},     64'h1);
    chk({t, " no_bus"},     {63'h0, o_mem_req_valid}, 64'h0);
  endtask

  initial begin
    //                sel we  size  uns  addr           wdata                  rdata                  berr trap e_addr         e_wdata                e_wstrb e_rdata                e_err
    vecs[0]  = '{1'b0, 1'b0, 2'd0, 1'b0, 32'h8000_0003, 64'h0,                 64'h80FF_1234,         1'b0, 1'b0, 32'h8000_0000, 64'h0,                 8'h00, 64'hFFFF_FF80,         2'd0};
    vecs[1]  = '{1'b0, 1'b1, 2'd1, 1'b0, 32'h8000_0002, 64'h0000_ABCD,         64'hDEAD_BEEF,         1'b0, 1'b0, 32'h8000_0000, 64'hABCD_0000,         8'h0C, 64'h0,                 2'd0};
    vecs[2]  = '{1'b0, 1'b0, 2'd1, 1'b1, 32'h8000_0002, 64'h0,                 64'h80FF_1234,         1'b0, 1'b0, 32'h8000_0000, 64'h0,                 8'h00, 64'h0000_80FF,         2'd0};
    vecs[3]  = '{1'b0, 1'b0, 2'd1, 1'b0, 32'h8000_0000, 64'h0,                 64'h80FF_9234,         1'b0, 1'b0, 32'h8000_0000, 64'h0,                 8'h00, 64'hFFFF_9234,         2'd0};
    vecs[4]  = '{1'b0, 1'b0, 2'd2, 1'b0, 32'h1000_0004, 64'h0,                 64'h1234_5678,         1'b0, 1'b0, 32'h1000_0004, 64'h0,                 8'h00, 64'h1234_5678,         2'd0};
    vecs[5]  = '{1'b0, 1'b1, 2'd0, 1'b0, 32'h0000_0001, 64'h1122_33A5,         64'h0,                 1'b0, 1'b0, 32'h0000_0000, 64'h2233_A500,         8'h02, 64'h0,                 2'd0};
    vecs[6]  = '{1'b0, 1'b0, 2'd0, 1'b1, 32'h0000_0002, 64'h0,                 64'h80FF_1234,         1'b0, 1'b0, 32'h0000_0000, 64'h0,                 8'h00, 64'h0000_00FF,         2'd0};
    vecs[7]  = '{1'b0, 1'b0, 2'd1, 1'b0, 32'h8000_0001, 64'h0,                 64'h0,                 1'b0, 1'b1, 32'h0,         64'h0,                 8'h00, 64'h0,                 2'd1};
    vecs[8]  = '{1'b0, 1'b0, 2'd3, 1'b0, 32'h8000_0000, 64'h0,                 64'h0,                 1'b0, 1'b1, 32'h0,         64'h0,                 8'h00, 64'h0,                 2'd3};
    vecs[9]  = '{1'b0, 1'b0, 2'd2, 1'b0, 32'h8000_0002, 64'h0,                 64'h0,                 1'b0, 1'b1, 32'h0,         64'h0,                 8'h00, 64'h0,                 2'd1};
    vecs[10] = '{1'b0, 1'b0, 2'd2, 1'b0, 32'h2000_0000, 64'h0,                 64'h1234_5678,         1'b1, 1'b0, 32'h2000_0000, 64'h0,                 8'h00, 64'h0,                 2'd2};
    vecs[11] = '{1'b1, 1'b0, 2'd2, 1'b1, 32'h8000_0004, 64'h0,                 64'h8765_4321_0000_0000, 1'b0, 1'b0, 32'h8000_0000, 64'h0,               8'h00, 64'h0000_0000_8765_4321, 2'd0};
    vecs[12] = '{1'b1, 1'b0, 2'd2, 1'b0, 32'h8000_0004, 64'h0,                 64'h8765_4321_0000_0000, 1'b0, 1'b0, 32'h8000_0000, 64'h0,               8'h00, 64'hFFFF_FFFF_8765_4321, 2'd0};
    vecs[13] = '{1'b1, 1'b0, 2'd3, 1'b0, 32'h8000_0008, 64'h0,                 64'h8765_4321_0000_0000, 1'b0, 1'b0, 32'h8000_0008, 64'h0,               8'h00, 64'h8765_4321_0000_0000, 2'd0};
    vecs[14] = '{1'b1, 1'b1, 2'd2, 1'b0, 32'h8000_0004, 64'h0000_0000_CAFE_F00D, 64'h0,               1'b0, 1'b0, 32'h8000_0000, 64'hCAFE_F00D_0000_0000, 8'hF0, 64'h0,                 2'd0};
    vecs[15] = '{1'b1, 1'b0, 2'd3, 1'b0, 32'h8000_0004, 64'h0,                 64'h0,                 1'b0, 1'b1, 32'h0,         64'h0,                 8'h00, 64'h0,                 2'd1};
    vecs[16] = '{1'b1, 1'b0, 2'd0, 1'b0, 32'h8000_0007, 64'h0,                 64'h8765_4321_0000_0000, 1'b0, 1'b0, 32'h8000_0000, 64'h0,               8'h00, 64'hFFFF_FFFF_FFFF_FF87, 2'd0};
    vecs[17] = '{1'b1, 1'b1, 2'd0, 1'b0, 32'h8000_0003, 64'h0000_0000_0000_00EE, 64'h0,               1'b0, 1'b0, 32'h8000_0000, 64'h0000_0000_EE00_0000, 8'h08, 64'h0,                 2'd0};

    rst_n = 1'b0; sel64 = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 32'h0; req_wdata = 64'h0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_err = 1'b0;
    mem_rdata = 64'h0; resp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    rst_n = 1'b1;
    step();

    for (int i = 0; i < NV; i++) begin
      run_vec(i, vecs[i]);
    end

    // Bus stalls, error response, and a write-back side that holds off
    sel64 = 1'b0;
    #1;
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
    req_addr = 32'h4000_0000; req_wdata = 64'h5A5A_1234;
    step();
    req_valid = 1'b0; req_wdata = 64'h0; req_addr = 32'hFFFF_FFFF;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("stall%0d mem_valid", k), {63'h0, o_mem_req_valid}, 64'h1);
      chk($sformatf("stall%0d mem_addr", k),  {32'h0, o_mem_addr},      64'h4000_0000);
      chk($sformatf("stall%0d mem_wdata", k), o_mem_wdata,              64'h5A5A_1234);
      chk($sformatf("stall%0d mem_wstrb", k), {56'h0, o_mem_wstrb},     64'h0F);
      chk($sformatf("stall%0d mem_we", k),    {63'h0, o_mem_we},        64'h1);
      if (k == 3) mem_req_ready = 1'b1;
      step();
    end
    mem_req_ready = 1'b0;
    chk("stall wait mem_valid", {63'h0, o_mem_req_valid}, 64'h0);
    chk("stall wait resp",      {63'h0, o_resp_valid},    64'h0);
    step();
    chk("stall wait2 resp",     {63'h0, o_resp_valid},    64'h0);
    mem_resp_valid = 1'b1; mem_resp_err = 1'b1; mem_rdata = 64'hFFFF_FFFF;
    step();
    mem_resp_valid = 1'b0; mem_resp_err = 1'b0;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("hold%0d resp_valid", k), {63'h0, o_resp_valid}, 64'h1);
      chk($sformatf("hold%0d resp_err", k),   {62'h0, o_resp_err},   64'h2);
      chk($sformatf("hold%0d resp_rdata", k), o_resp_rdata,          64'h0);
      chk($sformatf("hold%0d req_ready", k),  {63'h0, o_req_ready},  64'h0);
      step();
    end
    resp_ready = 1'b1;
    chk("hold2 resp_valid", {63'h0, o_resp_valid}, 64'h1);
    step();
    resp_ready = 1'b0;
    chk("stall release req_ready", {63'h0, o_req_ready},  64'h1);
    chk("stall release resp",      {63'h0, o_resp_valid}, 64'h0);

    // Reset while waiting for the bus response, then a stray late response
    sel64 = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2;
    req_addr = 32'h3000_0008; req_wdata = 64'h0;
    step();
    req_valid = 1'b0;
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    chk("pre-rst mem_addr", {32'h0, o_mem_addr}, 64'h3000_0008);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("midrst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    mem_resp_valid = 1'b1; mem_rdata = 64'h1234_5678;
    step();
    mem_resp_valid = 1'b0;
    chk("stray resp_valid",  {63'h0, o_resp_valid},    64'h0);
    chk("stray req_ready",   {63'h0, o_req_ready},     64'h1);
    step();
    chk("stray resp_valid2", {63'h0, o_resp_valid},    64'h0);
    chk("stray mem_valid",   {63'h0, o_mem_req_valid}, 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
